// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the FFT pipeline stages.
// tw_val builds rounded fixed-point twiddles from a Taylor series.
package fft_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_FILL = 2'd1,
    PH_BFLY = 2'd2
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [31:0] c;
    logic signed [31:0] s;
  } tw_pair_t;

  localparam real PI_R = 3.14159265358979323846;

  function automatic int clog2(int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width of the twiddle index k; at least one bit even when L = 1.
  function automatic int k_width(int l);
    return (l >= 2) ? clog2(l) : 1;
  endfunction

  // Round half away from zero, clamped to the signed range of a w-bit word.
  function automatic logic signed [31:0] round_haz(real v, int w);
    longint r;
    longint lim;
    if (v >= 0.0) r = longint'($rtoi(v + 0.5));
    else          r = -longint'($rtoi(-v + 0.5));
    lim = (longint'(1) << (w - 1)) - 1;
    if (r > lim)  r = lim;
    if (r < -lim) r = -lim;
    return r[31:0];
  endfunction

  function automatic tw_pair_t tw_val(int n, int stage, int k, int frac, int w);
    tw_pair_t res;
    real x, t, c, s, scale;
    int l;
    l = n >> (stage + 1);
    x = PI_R * real'(k) / real'(l);
    c = 1.0;
    t = 1.0;
    for (int i = 1; i < 16; i++) begin
      t = -t * x * x / real'((2 * i - 1) * (2 * i));
      c = c + t;
    end
    s = x;
    t = x;
    for (int i = 1; i < 16; i++) begin
      t = -t * x * x / real'((2 * i) * (2 * i + 1));
      s = s + t;
    end
    scale = real'(1 << frac);
    res.c = round_haz(c * scale, w);
    res.s = round_haz(s * scale, w);
    return res;
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Quarter-wave cosine table for one SDF stage; k -> (cos, sin) of pi*k/L.
// Sine and the second quadrant are folded onto the same L/2+1 entries.
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int N     = 32,
  parameter int STAGE = 0,
  parameter int W     = 24,
  parameter int FRAC  = 8
) (
  input  logic [k_width(N >> (STAGE + 1))-1:0] k,
  output logic signed [W-1:0]                  cos_v,
  output logic signed [W-1:0]                  sin_v
);

  localparam int L  = N >> (STAGE + 1);
  localparam int H  = (L >= 2) ? L / 2 : 0;
  localparam int KW = k_width(L);

  logic signed [W-1:0] tbl [0:H];
  logic [KW-1:0] idx_c;
  logic [KW-1:0] idx_s;
  logic          mirror;

  for (genvar j = 0; j <= H; j++) begin : g_tbl
    localparam tw_pair_t P = tw_val(N, STAGE, j, FRAC, W);
    assign tbl[j] = P.c[W-1:0];
  end

  // sin(pi*k/L) = cos(pi*(L/2-k)/L); past L/2 the cosine mirrors with a sign flip.
  always_comb begin
    mirror = 1'b0;
    idx_c  = k;
    idx_s  = KW'(H) - k;
    if (k > KW'(H)) begin
      mirror = 1'b1;
      idx_c  = KW'(L) - k;
      idx_s  = k - KW'(H);
    end
  end

  assign cos_v = mirror ? -tbl[idx_c] : tbl[idx_c];
  assign sin_v = (L < 2) ? '0 : tbl[idx_s];

endmodule

// File: rtl/fft_twiddle_seq.sv
// Twiddle sequencer for one radix-2 SDF stage: fill/butterfly halves,
// registered twiddle per sample, and an L-cycle self-drain after the last sample.
module fft_twiddle_seq
  import fft_pkg::*;
#(
  parameter int N     = 32,
  parameter int STAGE = 0,
  parameter int W     = 24,
  parameter int FRAC  = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic         last,
  input  logic         inv,
  output logic         out_valid,
  output logic [1:0]   phase,
  output logic [W-1:0] w_r,
  output logic [W-1:0] w_i,
  output logic         busy
);

  localparam int L  = N >> (STAGE + 1);
  localparam int CW = clog2(2 * L);
  localparam int KW = k_width(L);
  localparam int FW = clog2(L) + 1;
  localparam logic signed [W-1:0] ONE = W'(1 << FRAC);

  state_t              state;
  phase_t              ph_r;
  logic [CW-1:0]       cnt;
  logic [FW-1:0]       fcnt;
  logic                inv_q;
  logic signed [W-1:0] wr_r;
  logic signed [W-1:0] wi_r;

  logic                advance;
  logic                flush_done;
  logic                fill;
  logic [KW-1:0]       rom_k;
  logic signed [W-1:0] rom_c;
  logic signed [W-1:0] rom_s;

  assign advance    = in_valid | (state == ST_FLUSH);
  assign flush_done = (state == ST_FLUSH) && !in_valid && (fcnt == FW'(L - 1));
  assign fill       = cnt < CW'(L);
  // In the butterfly half cnt - L is just cnt without its top bit; L = 1 pins k to 0.
  assign rom_k      = (L >= 2) ? cnt[KW-1:0] : '0;

  twiddle_rom #(.N(N), .STAGE(STAGE), .W(W), .FRAC(FRAC)) u_rom (
    .k     (rom_k),
    .cos_v (rom_c),
    .sin_v (rom_s)
  );

  // Output stage: one-cycle latency from an advance to out_valid/phase/w_*
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      fcnt      <= '0;
      inv_q     <= 1'b0;
      out_valid <= 1'b0;
      ph_r      <= PH_IDLE;
      wr_r      <= ONE;
      wi_r      <= '0;
    end else begin
      if (advance) begin
        cnt       <= flush_done ? '0 : cnt + 1'b1;
        out_valid <= 1'b1;
        if (cnt == '0) inv_q <= inv;
        if (fill) begin
          ph_r <= PH_FILL;
          wr_r <= ONE;
          wi_r <= '0;
        end else begin
          ph_r <= PH_BFLY;
          wr_r <= rom_c;
          wi_r <= inv_q ? rom_s : -rom_s;
        end
      end else begin
        out_valid <= 1'b0;
        ph_r      <= PH_IDLE;
      end

      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state <= last ? ST_FLUSH : ST_RUN;
            busy  <= 1'b1;
            fcnt  <= '0;
          end
        end
        ST_RUN: begin
          if (in_valid && last) begin
            state <= ST_FLUSH;
            fcnt  <= '0;
          end
        end
        ST_FLUSH: begin
          if (in_valid) begin
            state <= last ? ST_FLUSH : ST_RUN;
            fcnt  <= '0;
          end else if (flush_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            fcnt  <= '0;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign phase = ph_r;
  assign w_r   = wr_r;
  assign w_i   = wi_r;

endmodule

// File: tb/tb_fft_twiddle_seq.sv
// Directed bench for fft_twiddle_seq: N=32 at STAGE 0 (L=16) and STAGE 4 (L=1),
// with hand-computed twiddle constants and vector queues per scenario.
module tb_fft_twiddle_seq;

  localparam int W = 24;

  logic clk;
  logic reset_n;
  logic in_valid;
  logic last;
  logic inv;

  logic         ov0, busy0;
  logic [1:0]   ph0;
  logic [W-1:0] wr0, wi0;
  logic         ov4, busy4;
  logic [1:0]   ph4;
  logic [W-1:0] wr4, wi4;

  fft_twiddle_seq #(.N(32), .STAGE(0), .W(W), .FRAC(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .last(last), .inv(inv),
    .out_valid(ov0), .phase(ph0), .w_r(wr0), .w_i(wi0), .busy(busy0)
  );

  fft_twiddle_seq #(.N(32), .STAGE(4), .W(W), .FRAC(8)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .last(last), .inv(inv),
    .out_valid(ov4), .phase(ph4), .w_r(wr4), .w_i(wi4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // round(256*cos(pi*k/16)) and round(256*sin(pi*k/16)), k = 0..15
  int cos_t [16] = '{256, 251, 237, 213, 181, 142, 98, 50,
                     0, -50, -98, -142, -181, -213, -237, -251};
  int sin_t [16] = '{0, 50, 98, 142, 181, 213, 237, 251,
                     256, 251, 237, 213, 181, 142, 98, 50};

  typedef struct {
    logic iv;
    logic lst;
    logic inv_in;
    logic ov;
    int   ph;
    int   wr;
    int   wi;
    int   p4;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;
  bit   track4 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic signed [31:0] act, logic signed [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else passed++;
  endtask

  task automatic add(logic iv, logic lst, logic inv_in, logic ov, int ph, int wr, int wi, int p4);
    vec_t v;
    v.iv = iv; v.lst = lst; v.inv_in = inv_in; v.ov = ov;
    v.ph = ph; v.wr = wr; v.wi = wi; v.p4 = p4;
    vq.push_back(v);
  endtask

  task automatic add_samples(int c0, int n, logic inv_in, logic inv_exp, logic last_end);
    for (int j = 0; j < n; j++) begin
      int c;
      int p4;
      logic lst;
      c   = (c0 + j) % 32;
      p4  = track4 ? ((j % 2 == 0) ? 1 : 2) : 0;
      lst = last_end && (j == n - 1);
      if (c < 16) add(1'b1, lst, inv_in, 1'b1, 1, 256, 0, p4);
      else add(1'b1, lst, inv_in, 1'b1, 2, cos_t[c-16],
               inv_exp ? sin_t[c-16] : -sin_t[c-16], p4);
    end
  endtask

  task automatic add_idle(int wr, int wi);
    add(1'b0, 1'b0, 1'b0, 1'b0, 0, wr, wi, 0);
  endtask

  task automatic add_flush(int n);
    for (int j = 0; j < n; j++) add(1'b0, 1'b0, 1'b0, 1'b1, 1, 256, 0, 0);
  endtask

  task automatic run_queue(string tag);
    for (int i = 0; i < vq.size(); i++) begin
      in_valid = vq[i].iv;
      last     = vq[i].lst;
      inv      = vq[i].inv_in;
      tick();
      chk($sformatf("%s[%0d] out_valid", tag, i), {31'b0, ov0}, {31'b0, vq[i].ov});
      chk($sformatf("%s[%0d] phase", tag, i), {30'b0, ph0}, vq[i].ph);
      chk($sformatf("%s[%0d] w_r", tag, i), $signed(wr0), vq[i].wr);
      chk($sformatf("%s[%0d] w_i", tag, i), $signed(wi0), vq[i].wi);
      if (vq[i].p4 != 0) begin
        chk($sformatf("%s[%0d] L1 phase", tag, i), {30'b0, ph4}, vq[i].p4);
        chk($sformatf("%s[%0d] L1 w_r", tag, i), $signed(wr4), 256);
        chk($sformatf("%s[%0d] L1 w_i", tag, i), $signed(wi4), 0);
      end
    end
    in_valid = 1'b0;
    last     = 1'b0;
    vq.delete();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " out_valid"}, {31'b0, ov0}, 0);
    chk({tag, " phase"}, {30'b0, ph0}, 0);
    chk({tag, " w_r"}, $signed(wr0), 256);
    chk({tag, " w_i"}, $signed(wi0), 0);
    chk({tag, " busy"}, {31'b0, busy0}, 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    last     = 1'b0;
    inv      = 1'b0;
    repeat (2) tick();
    chk_reset_vals("reset");
    chk("reset L1 busy", {31'b0, busy4}, 0);
    reset_n = 1'b1;
    tick();

    // Full block in FFT mode, then a stall that must hold the last twiddle.
    track4 = 1;
    add_samples(0, 32, 1'b0, 1'b0, 1'b0);
    track4 = 0;
    add_idle(-251, -50);
    run_queue("fft_block");
    chk("fft_block busy", {31'b0, busy0}, 1);

    // IFFT latched at cnt=0; dropping inv mid-block must not affect the block.
    add_samples(0, 10, 1'b1, 1'b1, 1'b0);
    add_samples(10, 22, 1'b0, 1'b1, 1'b0);
    run_queue("ifft_block");

    // One-cycle gap after sample 5, last on sample 32, then a 16-cycle drain.
    add_samples(0, 5, 1'b0, 1'b0, 1'b0);
    add_idle(256, 0);
    add_samples(5, 27, 1'b0, 1'b0, 1'b1);
    add_flush(16);
    add_idle(256, 0);
    run_queue("gap_flush");
    chk("gap_flush busy", {31'b0, busy0}, 0);
    chk("gap_flush L1 busy", {31'b0, busy4}, 0);

    // Input resumes after three drain cycles; must continue at cnt=3 with no hole.
    add_samples(0, 32, 1'b0, 1'b0, 1'b1);
    add_flush(3);
    add_samples(3, 29, 1'b0, 1'b0, 1'b0);
    run_queue("rejoin");
    chk("rejoin busy", {31'b0, busy0}, 1);

    // Asynchronous reset while in the butterfly half.
    add_samples(0, 20, 1'b0, 1'b0, 1'b0);
    run_queue("pre_reset");
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    tick();
    reset_n = 1'b1;
    add_samples(0, 17, 1'b0, 1'b0, 1'b0);
    run_queue("post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
